// File: rtl/multiport_reg_file.sv
// Multi-ported physical register file with per-register ready bits.
// Reads are registered, with write-to-read bypass and a stallable held read address.
module multiport_reg_file #(
   parameter int unsigned NUM_PR    = 64,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned NUM_WR    = 4,
   parameter int unsigned NUM_RD    = 8,
   parameter int unsigned NUM_ALLOC = 2,
   localparam int unsigned AW       = $clog2(NUM_PR)
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic                              i_stall,
   input  logic                              i_flush,
   input  logic [NUM_WR-1:0]                 i_wr_en,
   input  logic [NUM_WR-1:0][AW-1:0]         i_wr_addr,
   input  logic [NUM_WR-1:0][WIDTH-1:0]      i_wr_data,
   input  logic [NUM_RD-1:0]                 i_rd_en,
   input  logic [NUM_RD-1:0][AW-1:0]         i_rd_addr,
   output logic [NUM_RD-1:0][WIDTH-1:0]      o_rd_data,
   output logic [NUM_RD-1:0]                 o_rd_valid,
   input  logic [NUM_ALLOC-1:0]              i_alloc_en,
   input  logic [NUM_ALLOC-1:0][AW-1:0]      i_alloc_addr,
   output logic [NUM_PR-1:0]                 o_prf_ready
);

   logic [WIDTH-1:0]               r_mem [NUM_PR];
   logic [WIDTH-1:0]               w_mem_d [NUM_PR];
   logic [NUM_PR-1:0]              r_ready;
   logic [NUM_PR-1:0]              w_ready_d;
   logic [NUM_RD-1:0][AW-1:0]      r_rd_addr;
   logic [NUM_RD-1:0][AW-1:0]      w_rd_addr_sel;
   logic [NUM_RD-1:0][WIDTH-1:0]   r_rd_data;
   logic [NUM_RD-1:0][WIDTH-1:0]   w_rd_data_d;
   logic [NUM_RD-1:0]              r_rd_valid;

   // Post-write array image; later ports overwrite earlier ones, so the highest index wins.
   // Reads index this image, which gives the write-to-read bypass for free.
   always_comb begin
      w_mem_d = r_mem;
      for (int k = 0; k < NUM_WR; k++) begin
         if (i_wr_en[k] && (i_wr_addr[k] != '0)) begin
            w_mem_d[i_wr_addr[k]] = i_wr_data[k];
         end
      end
      w_mem_d[0] = '0;
   end

   // Allocation clears are applied after writeback sets so allocation wins.
   always_comb begin
      w_ready_d = r_ready;
      for (int k = 0; k < NUM_WR; k++) begin
         if (i_wr_en[k] && (i_wr_addr[k] != '0)) begin
            w_ready_d[i_wr_addr[k]] = 1'b1;
         end
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
         if (i_alloc_en[j] && (i_alloc_addr[j] != '0)) begin
            w_ready_d[i_alloc_addr[j]] = 1'b0;
         end
      end
      w_ready_d[0] = 1'b1;
   end

   always_comb begin
      w_rd_addr_sel = i_stall ? r_rd_addr : i_rd_addr;
      for (int p = 0; p < NUM_RD; p++) begin
         w_rd_data_d[p] = w_mem_d[w_rd_addr_sel[p]];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_PR; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PR; i++) begin
            r_mem[i] <= w_mem_d[i];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ready    <= '1;
         r_rd_addr  <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= '0;
      end else begin
         r_ready   <= w_ready_d;
         // Data refreshes every cycle, so a stalled read tracks writes to its held address.
         r_rd_data <= w_rd_data_d;
         if (!i_stall) begin
            r_rd_addr <= i_rd_addr;
         end
         if (i_flush) begin
            r_rd_valid <= '0;
         end else if (!i_stall) begin
            r_rd_valid <= i_rd_en;
         end
      end
   end

   assign o_rd_data   = r_rd_data;
   assign o_rd_valid  = r_rd_valid;
   assign o_prf_ready = r_ready;

endmodule

// File: tb/tb_multiport_reg_file.sv
// Bench for multiport_reg_file: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a behavioural model of the register file.
module tb_multiport_reg_file;

   localparam int unsigned NUM_PR    = 64;
   localparam int unsigned WIDTH     = 32;
   localparam int unsigned NUM_WR    = 4;
   localparam int unsigned NUM_RD    = 8;
   localparam int unsigned NUM_ALLOC = 2;
   localparam int unsigned AW        = $clog2(NUM_PR);

   logic                           clk;
   logic                           reset;
   logic                           stall;
   logic                           flush;
   logic [NUM_WR-1:0]              wr_en;
   logic [NUM_WR-1:0][AW-1:0]      wr_addr;
   logic [NUM_WR-1:0][WIDTH-1:0]   wr_data;
   logic [NUM_RD-1:0]              rd_en;
   logic [NUM_RD-1:0][AW-1:0]      rd_addr;
   logic [NUM_RD-1:0][WIDTH-1:0]   rd_data;
   logic [NUM_RD-1:0]              rd_valid;
   logic [NUM_ALLOC-1:0]           alloc_en;
   logic [NUM_ALLOC-1:0][AW-1:0]   alloc_addr;
   logic [NUM_PR-1:0]              prf_ready;

   multiport_reg_file #(
      .NUM_PR    (NUM_PR),
      .WIDTH     (WIDTH),
      .NUM_WR    (NUM_WR),
      .NUM_RD    (NUM_RD),
      .NUM_ALLOC (NUM_ALLOC)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_stall      (stall),
      .i_flush      (flush),
      .i_wr_en      (wr_en),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_rd_en      (rd_en),
      .i_rd_addr    (rd_addr),
      .o_rd_data    (rd_data),
      .o_rd_valid   (rd_valid),
      .i_alloc_en   (alloc_en),
      .i_alloc_addr (alloc_addr),
      .o_prf_ready  (prf_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NUM_RD-1:0]              valid;
      logic [NUM_RD-1:0][WIDTH-1:0]   data;
      logic [NUM_PR-1:0]              ready;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Architectural view: register contents, ready bits, and each read port's latched request.
   logic [WIDTH-1:0]  m_mem [NUM_PR];
   logic [NUM_PR-1:0] m_ready;
   logic [AW-1:0]     m_held [NUM_RD];
   logic [NUM_RD-1:0] m_valid;
   logic [WIDTH-1:0]  m_data [NUM_RD];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic model_step();
      exp_t e;
      if (reset) begin
         for (int i = 0; i < NUM_PR; i++) m_mem[i] = '0;
         m_ready = '1;
         m_valid = '0;
         for (int p = 0; p < NUM_RD; p++) begin
            m_held[p] = '0;
            m_data[p] = '0;
         end
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && wr_addr[k] != 0) begin
               m_mem[wr_addr[k]]   = wr_data[k];
               m_ready[wr_addr[k]] = 1'b1;
            end
         end
         for (int j = 0; j < NUM_ALLOC; j++) begin
            if (alloc_en[j] && alloc_addr[j] != 0) m_ready[alloc_addr[j]] = 1'b0;
         end
         m_ready[0] = 1'b1;
         if (!stall) begin
            for (int p = 0; p < NUM_RD; p++) m_held[p] = rd_addr[p];
         end
         for (int p = 0; p < NUM_RD; p++) m_data[p] = m_mem[m_held[p]];
         if (flush) m_valid = '0;
         else if (!stall) m_valid = rd_en;
      end
      e.valid = m_valid;
      e.ready = m_ready;
      for (int p = 0; p < NUM_RD; p++) e.data[p] = m_data[p];
      exp_q.push_back(e);
   endtask

   // One clock: predict the post-edge outputs, then move to the next falling edge.
   task automatic step();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      reset      = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      rd_en      = '0;
      rd_addr    = '0;
      alloc_en   = '0;
      alloc_addr = '0;
   endtask

   // Half the addresses come from a small window so port collisions happen often.
   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 15));
      return AW'($urandom_range(0, NUM_PR - 1));
   endfunction

   // Monitor: pops one prediction per clock edge and compares against the DUT.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_valid", 64'(rd_valid), 64'(e.valid));
            check("prf_ready", 64'(prf_ready), 64'(e.ready));
            for (int p = 0; p < NUM_RD; p++) begin
               if (e.valid[p]) begin
                  check($sformatf("rd_data[%0d]", p), 64'(rd_data[p]), 64'(e.data[p]));
               end
            end
         end
      end
   end

   initial begin
      idle();
      reset = 1'b1;
      step();
      step();
      check("reset_valid", 64'(rd_valid), 64'h0);
      check("reset_ready", 64'(prf_ready), {64{1'b1}});

      // Write then read.
      idle();
      wr_en[0] = 1'b1; wr_addr[0] = 6'd5; wr_data[0] = 32'hDEADBEEF;
      step();
      idle();
      rd_en[3] = 1'b1; rd_addr[3] = 6'd5;
      step();
      check("wr_rd_data", 64'(rd_data[3]), 64'hDEADBEEF);
      check("wr_rd_valid", 64'(rd_valid[3]), 64'h1);

      // Same-cycle write priority and bypass.
      idle();
      wr_en[0] = 1'b1; wr_addr[0] = 6'd9; wr_data[0] = 32'h11;
      wr_en[3] = 1'b1; wr_addr[3] = 6'd9; wr_data[3] = 32'h33;
      rd_en[0] = 1'b1; rd_addr[0] = 6'd9;
      step();
      check("bypass_prio", 64'(rd_data[0]), 64'h33);
      idle();
      rd_en[5] = 1'b1; rd_addr[5] = 6'd9;
      step();
      check("prio_later", 64'(rd_data[5]), 64'h33);

      // Stall refresh at the held address.
      idle();
      wr_en[1] = 1'b1; wr_addr[1] = 6'd12; wr_data[1] = 32'h1;
      step();
      idle();
      rd_en[0] = 1'b1; rd_addr[0] = 6'd12;
      step();
      check("stall_pre", 64'(rd_data[0]), 64'h1);
      idle();
      stall = 1'b1; rd_addr[0] = 6'd7;
      wr_en[2] = 1'b1; wr_addr[2] = 6'd12; wr_data[2] = 32'h2;
      step();
      check("stall_refresh", 64'(rd_data[0]), 64'h2);
      check("stall_valid", 64'(rd_valid[0]), 64'h1);
      wr_en = '0;
      step();
      check("stall_hold", 64'(rd_data[0]), 64'h2);

      // Flush overrides stall.
      flush = 1'b1;
      step();
      check("flush_stall", 64'(rd_valid), 64'h0);

      // Ready tracking.
      idle();
      alloc_en[0] = 1'b1; alloc_addr[0] = 6'd20;
      step();
      check("alloc_clr", 64'(prf_ready[20]), 64'h0);
      idle();
      alloc_en[1] = 1'b1; alloc_addr[1] = 6'd20;
      wr_en[3] = 1'b1; wr_addr[3] = 6'd20; wr_data[3] = 32'hABCD;
      step();
      check("alloc_over_wr", 64'(prf_ready[20]), 64'h0);
      idle();
      wr_en[0] = 1'b1; wr_addr[0] = 6'd20; wr_data[0] = 32'h5555;
      step();
      check("wr_set", 64'(prf_ready[20]), 64'h1);

      // Register zero.
      idle();
      wr_en[2] = 1'b1; wr_addr[2] = 6'd0; wr_data[2] = 32'hFFFF;
      alloc_en[0] = 1'b1; alloc_addr[0] = 6'd0;
      rd_en = '1;
      step();
      check("r0_ready", 64'(prf_ready[0]), 64'h1);
      idle();
      rd_en = '1;
      step();
      for (int p = 0; p < NUM_RD; p++) check($sformatf("r0_read[%0d]", p), 64'(rd_data[p]), 64'h0);

      // Reset while stalled with valid reads and pending writes.
      idle();
      stall = 1'b1; reset = 1'b1; rd_en = '1;
      wr_en[1] = 1'b1; wr_addr[1] = 6'd9; wr_data[1] = 32'h77;
      alloc_en[0] = 1'b1; alloc_addr[0] = 6'd30;
      step();
      check("rst_stall_valid", 64'(rd_valid), 64'h0);
      check("rst_stall_ready", 64'(prf_ready), {64{1'b1}});
      for (int p = 0; p < NUM_RD; p++) check($sformatf("rst_data[%0d]", p), 64'(rd_data[p]), 64'h0);
      idle();
      for (int p = 0; p < NUM_RD; p++) begin
         rd_en[p] = 1'b1; rd_addr[p] = AW'(5 + 4 * p);
      end
      rd_addr[1] = 6'd9;
      step();
      for (int p = 0; p < NUM_RD; p++) check($sformatf("post_rst[%0d]", p), 64'(rd_data[p]), 64'h0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 11) == 0);
         for (int k = 0; k < NUM_WR; k++) begin
            wr_en[k]   = 1'($urandom_range(0, 1));
            wr_addr[k] = rand_addr();
            wr_data[k] = $urandom();
         end
         for (int p = 0; p < NUM_RD; p++) begin
            rd_en[p]   = ($urandom_range(0, 3) != 0);
            rd_addr[p] = rand_addr();
         end
         for (int j = 0; j < NUM_ALLOC; j++) begin
            alloc_en[j]   = ($urandom_range(0, 2) == 0);
            alloc_addr[j] = rand_addr();
         end
         step();
      end

      idle();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      check("scoreboard_drain", 64'(exp_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multiport_reg_file.md
MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 SHALL have parameter NUM_PR, default 64, number of physical registers (power of 2, >=8).
REQ-002 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-003 SHALL have parameter NUM_WR, default 4, write (writeback) port count.
REQ-004 SHALL have parameter NUM_RD, default 8, read port count.
REQ-005 SHALL have parameter NUM_ALLOC, default 2, allocation port count; AW = $clog2(NUM_PR).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port stall  input  1  holds read pipeline stage.
REQ-009 SHALL have port flush  input  1  invalidates read outputs.
REQ-010 SHALL have ports wr_en[NUM_WR] input 1, wr_addr[NUM_WR] input AW, wr_data[NUM_WR] input WIDTH; per-port writeback.
REQ-011 SHALL have ports rd_en[NUM_RD] input 1, rd_addr[NUM_RD] input AW; per-port read request.
REQ-012 SHALL have ports rd_data[NUM_RD] output WIDTH, rd_valid[NUM_RD] output 1; registered read results.
REQ-013 SHALL have ports alloc_en[NUM_ALLOC] input 1, alloc_addr[NUM_ALLOC] input AW; destination allocation.
REQ-014 SHALL have port prf_ready output NUM_PR; per-register ready bit, bit i = register i.

Function
REQ-015 SHALL store NUM_PR x WIDTH entries; physical register 0 SHALL read 0 and ignore writes.
REQ-016 SHALL write wr_data[k] to wr_addr[k] at posedge when wr_en[k]=1 and wr_addr[k]!=0, independent of stall and flush.
REQ-017 SHALL resolve same-cycle writes to one address by highest port index wins.
REQ-018 SHALL have read latency 1: rd_data[p] in cycle N+1 = value of rd_addr[p] after cycle-N writes are applied (write-to-read bypass, same priority as REQ-017).
REQ-019 SHALL register rd_addr[p] into an internal held address when stall=0; when stall=1 the held address SHALL be kept and rd_data[p] SHALL refresh each cycle from array plus bypass at that held address.
REQ-020 SHALL set rd_valid[p] <= rd_en[p] when stall=0 and flush=0; hold when stall=1 and flush=0.
REQ-021 SHALL clear all rd_valid next cycle when flush=1, overriding stall; rd_data is don't-care when rd_valid=0.
REQ-022 SHALL clear prf_ready[alloc_addr[j]] at posedge when alloc_en[j]=1 and alloc_addr[j]!=0.
REQ-023 SHALL set prf_ready[wr_addr[k]] at posedge when wr_en[k]=1 and wr_addr[k]!=0.
REQ-024 SHALL give allocation priority over writeback when both target the same register in one cycle (result: not ready, data written).
REQ-025 SHALL keep prf_ready[0]=1 always; prf_ready SHALL be driven directly from flops (no combinational path from inputs).
REQ-026 SHALL apply ready updates regardless of stall and flush.
REQ-027 SHALL accept any rd_addr, including duplicates across ports, each port returning identical data.

Reset
REQ-028 SHALL on reset=1 at posedge: all entries to 0, all prf_ready bits to 1, all rd_valid to 0, all rd_data to 0, held addresses to 0.
REQ-029 SHALL ignore wr_en, alloc_en, rd_en, stall, flush in a reset cycle; reset mid-stall SHALL leave outputs in reset state next cycle.

Verification
REQ-030 SHALL verify write-then-read: cycle0 wr_en[0]=1 addr 5 data 0xDEADBEEF; cycle1 rd_en[3]=1 addr 5 -> cycle2 rd_data[3]=0xDEADBEEF, rd_valid[3]=1.
REQ-031 SHALL verify bypass and priority: same cycle wr port0 addr 9 data 0x11, port3 addr 9 data 0x33, rd_en[0] addr 9 -> next cycle rd_data[0]=0x33; later read of 9 =0x33.
REQ-032 SHALL verify stall refresh: read addr 12 (value 0x1), stall=1, during stall write 0x2 to 12 -> rd_data holds addr 12, becomes 0x2 one cycle after write, rd_valid stays 1.
REQ-033 SHALL verify flush over stall: rd_valid=1, stall=1 and flush=1 -> next cycle all rd_valid=0.
REQ-034 SHALL verify ready tracking: alloc addr 20 -> prf_ready[20]=0; same cycle alloc 20 and write 20 -> prf_ready[20]=0; write 20 alone -> prf_ready[20]=1.
REQ-035 SHALL verify register 0: write 0xFFFF to addr 0, alloc addr 0 -> reads of 0 return 0, prf_ready[0]=1; reset after writes -> all reads 0, all prf_ready=1.
